// File: rtl/ser_rx_unit.sv
// 8N1 UART receiver with 2-flop input sync, start/stop validation and a FWFT byte FIFO with sticky error flags.
// Byte visible one clk after the stop-bit sample; a full FIFO drops new bytes (overrun) unless popped in the same cycle.
module ser_rx_unit #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ser_rxd,
    input  logic       rd_en,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_full,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0]      CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]      CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   FILL_ONE = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]   FILL_MAX = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAITHI
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shreg_q, shreg_d;
    logic               rxd_m_q, rxd_s_q;
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               frame_err_q, overrun_q;

    logic push, frame_set, pop, full, accept, ovr_set;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        push      = 1'b0;
        frame_set = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!rxd_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxd_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rxd_s_q;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rxd_s_q) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = S_WAITHI;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WAITHI: begin
                // A break holds the line low; wait for idle so it reports only once.
                if (rxd_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pop     = rd_en & rx_valid;
    assign full    = (count_q == FILL_MAX);
    assign accept  = push & (~full | pop);
    assign ovr_set = push & full & ~pop;

    always_comb begin
        count_d = count_q;
        unique case ({accept, pop})
            2'b10:   count_d = count_q + FILL_ONE;
            2'b01:   count_d = count_q - FILL_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_m_q     <= 1'b1;
            rxd_s_q     <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rxd_m_q     <= ser_rxd;
            rxd_s_q     <= rxd_m_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            count_q     <= count_d;
            if (accept) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)    rd_ptr_q <= rd_ptr_q + PTR_ONE;
            frame_err_q <= frame_set | (frame_err_q & ~err_clr);
            overrun_q   <= ovr_set   | (overrun_q   & ~err_clr);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (accept) begin
            mem_q[wr_ptr_q] <= shreg_q;
        end
    end

    assign rx_valid  = (count_q != '0);
    assign rx_full   = full;
    assign rx_data   = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_ser_rx_unit.sv
// Bench for ser_rx_unit at 8 clk per bit, 4-entry FIFO: scoreboard queue of expected bytes,
// popped and compared by an independent monitor whenever the bench pops a valid head.
module tb_ser_rx_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       ser_rxd;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_full;
    logic       frame_err;
    logic       overrun;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    ser_rx_unit #(.CLKS_PER_BIT(8), .FIFO_AW(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .ser_rxd  (ser_rxd),
        .rd_en    (rd_en),
        .err_clr  (err_clr),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_full  (rx_full),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Each bit is held for exactly 8 clocks so every sample lands mid-bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit expect_push);
        if (expect_push) exp_q.push_back(b);
        ser_rxd = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ser_rxd = b[i];
            repeat (8) @(negedge clk);
        end
        ser_rxd = stop;
        repeat (8) @(negedge clk);
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: a pop happens at the next rising edge; compare the head against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rd_en && rx_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL pop_unexpected: got 0x%0h, expected no byte at %0t", rx_data, $time);
                end else begin
                    check("pop_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b0;
        ser_rxd = 1'b1;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rx_valid",  {31'h0, rx_valid},  0);
        check("rst_rx_full",   {31'h0, rx_full},   0);
        check("rst_rx_data",   {24'h0, rx_data},   0);
        check("rst_frame_err", {31'h0, frame_err}, 0);
        check("rst_overrun",   {31'h0, overrun},   0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // 1: valid 0xA5, exact one-cycle push latency after the stop sample.
        fork
            send_frame(8'hA5, 1'b1, 1'b1);
            begin
                repeat (78) @(negedge clk);
                #3 check("t1_valid_before_push", {31'h0, rx_valid}, 0);
                @(negedge clk);
                #3 check("t1_valid_after_push", {31'h0, rx_valid}, 1);
            end
        join
        check("t1_frame_err", {31'h0, frame_err}, 0);
        pop_one();
        check("t1_valid_after_pop", {31'h0, rx_valid}, 0);

        // 2: 3-clock glitch is rejected.
        ser_rxd = 1'b0;
        repeat (3) @(negedge clk);
        ser_rxd = 1'b1;
        repeat (24) @(negedge clk);
        check("t2_valid",     {31'h0, rx_valid},  0);
        check("t2_frame_err", {31'h0, frame_err}, 0);
        check("t2_overrun",   {31'h0, overrun},   0);

        // 3: bad stop bit, line held low for 20 bit times, then 0x11.
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (160) @(negedge clk);
        check("t3_valid_during_break", {31'h0, rx_valid}, 0);
        ser_rxd = 1'b1;
        repeat (16) @(negedge clk);
        send_frame(8'h11, 1'b1, 1'b1);
        check("t3_frame_err", {31'h0, frame_err}, 1);
        check("t3_valid",     {31'h0, rx_valid},  1);
        pop_one();
        check("t3_valid_after_pop", {31'h0, rx_valid}, 0);
        clear_errors();
        check("t3_frame_err_cleared", {31'h0, frame_err}, 0);

        // 4: five bytes without reads; the fifth overruns.
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b1);
        check("t4_full",        {31'h0, rx_full}, 1);
        check("t4_no_overrun",  {31'h0, overrun}, 0);
        send_frame(8'h05, 1'b1, 1'b0);
        check("t4_overrun",     {31'h0, overrun}, 1);
        check("t4_full_after",  {31'h0, rx_full}, 1);
        repeat (4) pop_one();
        check("t4_empty",       {31'h0, rx_valid}, 0);
        check("t4_not_full",    {31'h0, rx_full},  0);
        clear_errors();
        check("t4_overrun_cleared", {31'h0, overrun}, 0);

        // 5: pop in the exact stop-sample cycle of 0x77 while full.
        for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b1);
        check("t5_full_before", {31'h0, rx_full}, 1);
        fork
            send_frame(8'h77, 1'b1, 1'b1);
            begin
                repeat (78) @(negedge clk);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
            end
        join
        check("t5_overrun", {31'h0, overrun}, 0);
        check("t5_full",    {31'h0, rx_full}, 1);
        repeat (4) pop_one();
        check("t5_empty",   {31'h0, rx_valid}, 0);

        // 6: reset mid-frame with a byte buffered and an error flagged.
        send_frame(8'h99, 1'b1, 1'b1);
        send_frame(8'h00, 1'b0, 1'b0);
        ser_rxd = 1'b1;
        repeat (16) @(negedge clk);
        check("t6_valid_pre",     {31'h0, rx_valid},  1);
        check("t6_frame_err_pre", {31'h0, frame_err}, 1);
        ser_rxd = 1'b0;
        repeat (8) @(negedge clk);
        ser_rxd = 1'b1;
        repeat (8) @(negedge clk);
        ser_rxd = 1'b0;
        repeat (5) @(negedge clk);
        rst     = 1'b0;
        ser_rxd = 1'b1;
        @(negedge clk);
        exp_q.delete();
        check("t6_rst_valid",     {31'h0, rx_valid},  0);
        check("t6_rst_full",      {31'h0, rx_full},   0);
        check("t6_rst_data",      {24'h0, rx_data},   0);
        check("t6_rst_frame_err", {31'h0, frame_err}, 0);
        check("t6_rst_overrun",   {31'h0, overrun},   0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("t6_idle_after_rst", {31'h0, rx_valid}, 0);
        send_frame(8'h5A, 1'b1, 1'b1);
        check("t6_frame_err", {31'h0, frame_err}, 0);
        pop_one();
        check("t6_empty", {31'h0, rx_valid}, 0);

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
